vga_timing_scaler: RTL
======================

// Module: vga_timing_scaler
// PURPOSE
//  Generates 640x480@60Hz VGA timing from the system clock and maps the visible raster onto a
//  centred 128x128 video-memory window, with each memory pixel shown as a SCALE x SCALE block.
//  Sits upstream of vga_mem: drives its iVideoMemX/iVideoMemY read coordinates. Also provides
//  the sync and blanking strobes used by the colour output stage, plus a frame-start pulse.
// PARAMETERS
//  CLK_DIV      2    iClk cycles per pixel (50 MHz board clock -> 25 MHz pixel rate)
//  H_ACTIVE     640  visible pixels per line
//  H_FP         16   horizontal front porch, in pixels
//  H_SYNC       96   horizontal sync width, in pixels
//  H_BP         48   horizontal back porch, in pixels (H_TOTAL=800)
//  V_ACTIVE     480  visible lines
//  V_FP         10   vertical front porch, in lines
//  V_SYNC       2    vertical sync width, in lines
//  V_BP         33   vertical back porch, in lines (V_TOTAL=525)
//  MEM_WIDTH_X  128  memory window width, in memory pixels
//  MEM_WIDTH_Y  128  memory window height, in memory pixels
//  SCALE        3    screen pixels per memory pixel, on each axis
//  WIN_X0       128  first screen column of the window
//  WIN_Y0       48   first screen line of the window
// PORTS
//  iClk            in   1  system clock
//  iReset          in   1  asynchronous reset, active-high
//  oHSync          out  1  horizontal sync, active-low
//  oVSync          out  1  vertical sync, active-low
//  oVideoMemX      out  7  memory column; goes to vga_mem iVideoMemX
//  oVideoMemY      out  7  memory row; goes to vga_mem iVideoMemY
//  oInWindow       out  1  current pixel lies inside the scaled memory window
//  oDisplayActive  out  1  current pixel is visible (h<H_ACTIVE and v<V_ACTIVE)
//  oPixelTick      out  1  one-iClk pulse whenever the outputs above update
//  oFrameStart     out  1  one-iClk pulse when the outputs show position (0,0)
// BEHAVIOUR
//  - Reset (async, active-high): all counters go to 0.
//    Outputs: oHSync=1, oVSync=1; all other outputs 0.
//  - Prescaler: counts 0..CLK_DIV-1 and wraps. tick = (prescaler==CLK_DIV-1).
//  - Raster counters:
//    - hcount advances on each tick, range 0..799.
//    - At the tick with hcount==799, hcount wraps to 0 and vcount advances, range 0..524.
//    - vcount wraps 524->0.
//  - On each tick, every output is registered from the current (hcount,vcount); then the counters
//    advance. Outputs hold their value between ticks.
//    - The first tick after reset release is the CLK_DIV-th iClk edge; it presents (0,0).
//  - oPixelTick is a registered copy of tick: high for exactly one iClk, coincident with the output update.
//  - oHSync=0 iff hcount in [656,752). oVSync=0 iff vcount in [490,492).
//  - oDisplayActive=1 iff hcount<640 and vcount<480.
//  - Window: oInWindow=1 iff hcount in [WIN_X0, WIN_X0+SCALE*MEM_WIDTH_X) = [128,512)
//    and vcount in [WIN_Y0, WIN_Y0+SCALE*MEM_WIDTH_Y) = [48,432).
//  - Address mapping (no divider; sub-counters only):
//    - sx (0..SCALE-1) and memX (7 bit) step on ticks while hcount is inside the window columns.
//    - sx wraps at SCALE-1, and memX increments when sx wraps.
//    - Both clear when hcount is outside the window columns.
//    - sy and memY step once per line, at the hcount 799->0 wrap, while vcount is inside the window rows.
//    - sy and memY clear at the vcount wrap.
//    - Result: memX=(hcount-WIN_X0)/SCALE and memY=(vcount-WIN_Y0)/SCALE.
//  - Outside the window, oVideoMemX=oVideoMemY=0. Downstream colour logic gates on oInWindow/oDisplayActive.
//  - oFrameStart=1 for one iClk on the update that presents (0,0), including the first after reset.
//  - Reset mid-frame: outputs go to reset values immediately; the raster restarts at (0,0)
//    with oFrameStart on the first tick.
//  - Width rules: hcount is 10 bit and vcount is 10 bit. memX/memY never exceed 127.
// TESTING
//  1. Release reset, CLK_DIV=2 -> first oFrameStart on iClk edge 2; later pulses exactly 840000 clocks apart.
//  2. Line timing -> oHSync low for 192 clocks, starting 1312 clocks after line start; line period 1600 clocks.
//  3. Frame timing -> oVSync low for exactly 3200 clocks (lines 490-491); never low during lines 0..489.
//  4. Window mapping:
//     - (h=128,v=48) -> X=0,Y=0,oInWindow=1
//     - h=130 -> X=0; h=131 -> X=1; h=511 -> X=127
//     - h=512 -> oInWindow=0, X=0
//     - v=431 -> Y=127; v=432 -> oInWindow=0
//  5. Assert iReset at (h=300,v=200) for 3 clocks -> oHSync/oVSync=1 and others 0 immediately;
//     after release, the next update is (0,0) with oFrameStart=1.
//  6. Count per frame -> 307200 ticks with oDisplayActive=1 and 147456 with oInWindow=1;
//     every oInWindow tick also has oDisplayActive=1.

Source files
------------

// File: rtl/vga_timing_scaler.sv
// VGA raster timing generator (640x480@60 by default) that also maps the visible raster onto a
// centred, integer-scaled video-memory window and drives the memory read coordinates.
module vga_timing_scaler #(
    parameter int CLK_DIV     = 2,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int MEM_WIDTH_X = 128,
    parameter int MEM_WIDTH_Y = 128,
    parameter int SCALE       = 3,
    parameter int WIN_X0      = 128,
    parameter int WIN_Y0      = 48
) (
    input  logic       iClk,
    input  logic       iReset,
    output logic       oHSync,
    output logic       oVSync,
    output logic [6:0] oVideoMemX,
    output logic [6:0] oVideoMemY,
    output logic       oInWindow,
    output logic       oDisplayActive,
    output logic       oPixelTick,
    output logic       oFrameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SX_W    = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLK_DIV - 1);
    localparam logic [SX_W-1:0] SX_LAST  = SX_W'(SCALE - 1);
    localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]      H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]      V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]      HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]      HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]      VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]      VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]      WX0      = 10'(WIN_X0);
    localparam logic [9:0]      WX1      = 10'(WIN_X0 + SCALE * MEM_WIDTH_X);
    localparam logic [9:0]      WY0      = 10'(WIN_Y0);
    localparam logic [9:0]      WY1      = 10'(WIN_Y0 + SCALE * MEM_WIDTH_Y);

    logic [PS_W-1:0] prescaler_q, prescaler_d;
    logic [9:0]      hcount_q, hcount_d;
    logic [9:0]      vcount_q, vcount_d;
    logic [SX_W-1:0] sx_q, sx_d;
    logic [SX_W-1:0] sy_q, sy_d;
    logic [6:0]      mem_x_q, mem_x_d;
    logic [6:0]      mem_y_q, mem_y_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic [6:0]      vmem_x_q, vmem_x_d;
    logic [6:0]      vmem_y_q, vmem_y_d;
    logic            in_window_q, in_window_d;
    logic            active_q, active_d;
    logic            pixel_tick_q, pixel_tick_d;
    logic            frame_start_q, frame_start_d;

    logic tick;
    logic h_in_win;
    logic v_in_win;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        prescaler_d   = prescaler_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        sx_d          = sx_q;
        sy_d          = sy_q;
        mem_x_d       = mem_x_q;
        mem_y_d       = mem_y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        vmem_x_d      = vmem_x_q;
        vmem_y_d      = vmem_y_q;
        in_window_d   = in_window_q;
        active_d      = active_q;
        frame_start_d = 1'b0;

        tick         = (prescaler_q == PS_LAST);
        h_in_win     = (hcount_q >= WX0) && (hcount_q < WX1);
        v_in_win     = (vcount_q >= WY0) && (vcount_q < WY1);
        pixel_tick_d = tick;
        prescaler_d  = tick ? '0 : prescaler_q + PS_W'(1);

        if (tick) begin
            // Outputs capture the position being presented, before the counters move on.
            hsync_d       = !((hcount_q >= HS_START) && (hcount_q < HS_END));
            vsync_d       = !((vcount_q >= VS_START) && (vcount_q < VS_END));
            active_d      = (hcount_q < H_ACT) && (vcount_q < V_ACT);
            in_window_d   = h_in_win && v_in_win;
            vmem_x_d      = (h_in_win && v_in_win) ? mem_x_q : 7'd0;
            vmem_y_d      = (h_in_win && v_in_win) ? mem_y_q : 7'd0;
            frame_start_d = (hcount_q == 10'd0) && (vcount_q == 10'd0);

            if (h_in_win) begin
                if (sx_q == SX_LAST) begin
                    sx_d    = '0;
                    mem_x_d = mem_x_q + 7'd1;
                end else begin
                    sx_d = sx_q + SX_W'(1);
                end
            end else begin
                sx_d    = '0;
                mem_x_d = 7'd0;
            end

            if (hcount_q == H_LAST) begin
                hcount_d = 10'd0;
                if (vcount_q == V_LAST) begin
                    vcount_d = 10'd0;
                    sy_d     = '0;
                    mem_y_d  = 7'd0;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                    if (v_in_win) begin
                        if (sy_q == SX_LAST) begin
                            sy_d    = '0;
                            mem_y_d = mem_y_q + 7'd1;
                        end else begin
                            sy_d = sy_q + SX_W'(1);
                        end
                    end
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            prescaler_q   <= '0;
            hcount_q      <= 10'd0;
            vcount_q      <= 10'd0;
            sx_q          <= '0;
            sy_q          <= '0;
            mem_x_q       <= 7'd0;
            mem_y_q       <= 7'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            vmem_x_q      <= 7'd0;
            vmem_y_q      <= 7'd0;
            in_window_q   <= 1'b0;
            active_q      <= 1'b0;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            mem_x_q       <= mem_x_d;
            mem_y_q       <= mem_y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            vmem_x_q      <= vmem_x_d;
            vmem_y_q      <= vmem_y_d;
            in_window_q   <= in_window_d;
            active_q      <= active_d;
            pixel_tick_q  <= pixel_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign oHSync         = hsync_q;
    assign oVSync         = vsync_q;
    assign oVideoMemX     = vmem_x_q;
    assign oVideoMemY     = vmem_y_q;
    assign oInWindow      = in_window_q;
    assign oDisplayActive = active_q;
    assign oPixelTick     = pixel_tick_q;
    assign oFrameStart    = frame_start_q;

endmodule
